demux_class_n: RTL and testbench
================================

// Module: demux_class_n
// PURPOSE
//   Parametrised 1-to-NUM_CH class demultiplexer with flow control. Each accepted input word is
//   routed by its class field into one per-class output register. Each register is tagged
//   {class, dest, data}. Sits between the input FIFO and the per-class FIFOs; every out_valid
//   pulse is one push.
// PARAMETERS
//   DATA_W  8  payload width
//   CLS_W   2  class field width
//   NUM_CH  4  output channels; NUM_CH <= 2**CLS_W
//   CNT_W   8  width of the drop counter
// PORTS
//   clk          in   1                 rising-edge clock
//   reset_L      in   1                 synchronous reset, active low
//   in_valid     in   1                 input word present
//   data_in      in   DATA_W            payload
//   class_in     in   CLS_W             destination class index
//   dest_in      in   1                 destination tag, carried through
//   out_full     in   NUM_CH            downstream FIFO full, bit k = channel k
//   in_ready     out  1                 word accepted this cycle when in_valid=1
//   out_data     out  NUM_CH*OUT_W      OUT_W=DATA_W+1+CLS_W; slice k = {class,dest,data}
//   out_valid    out  NUM_CH            1-cycle push strobe per channel
//   err_drop     out  1                 1-cycle pulse, invalid-class word dropped
//   drop_cnt     out  CNT_W             saturating count of dropped words
// BEHAVIOUR
//   - Reset (reset_L=0 at posedge): out_data=0, out_valid=0, err_drop=0, drop_cnt=0.
//     Any word in flight is discarded; no output is produced for it.
//   - in_ready is combinational:
//       in_ready = reset_L & ((class_in>=NUM_CH) | ~out_full[class_in]).
//     Invalid classes are always accepted.
//   - Accept = in_valid & in_ready. Upstream holds data/class/dest stable while in_valid=1 and
//     in_ready=0.
//   - Latency 1 cycle: a word accepted in cycle n with class c < NUM_CH gives, in cycle n+1:
//       out_valid[c]=1 and slice c = {class_in, dest_in, data_in}.
//     All other out_valid bits are 0 in n+1.
//   - out_valid bits are one-hot or zero. There is no accept without a push, and no duplicate
//     push.
//   - Word accepted with class_in >= NUM_CH: no out_valid. err_drop=1 next cycle. drop_cnt
//     increments and saturates at 2**CNT_W-1 (no wrap).
//   - out_full[c] rising in the same cycle as in_valid with class c: stall. in_ready=0, no push.
//     The word is pushed in the cycle after out_full[c] falls.
//   - out_full on a channel other than class_in does not stall.
//     Throughput: 1 word/cycle when the target channel is not full.
//   - out_valid=0 and in_valid=0: no state change except the behaviour under HOLD_LAST_EN.
//   - Back-to-back words to the same channel give consecutive out_valid pulses and an updated
//     slice every cycle.
// CONFIGURATION
//   HOLD_LAST_EN defined:
//     slice k holds the last word pushed to channel k while out_valid[k]=0.
//     This is the legacy hold-previous-value behaviour. Cleared only by reset.
//   HOLD_LAST_EN undefined:
//     slice k is forced to 0 in every cycle where out_valid[k]=0.
//   All other behaviour is identical in both builds.
// TESTING
//   1 Reset: hold reset_L=0 3 cycles with in_valid=1 -> in_ready=0; all outputs 0; drop_cnt=0.
//   2 Routing: data 8'hA5 cls 2 dest 1, then 8'h3C cls 0 dest 0 back-to-back ->
//     out_valid=4'b0100, slice2={2'd2,1,A5}; next cycle out_valid=4'b0001, slice0={0,0,3C}.
//   3 Backpressure: out_full[1]=1 for 4 cycles, word cls 1 held -> in_ready=0, no push.
//     out_full[1]->0 -> exactly one push on ch1.
//     Meanwhile a cls 3 word with out_full[3]=0 is accepted.
//   4 Drop: NUM_CH=3, send 300 words of cls 3 -> err_drop pulses each time.
//     drop_cnt saturates at 255; out_valid stays 0.
//   5 Reset mid-stream: reset_L=0 the cycle after accepting cls 1 word 8'h77 ->
//     out_valid=0 next cycle, slice1=0.
//   6 Hold option: push 8'h11 to ch0, then idle 2 cycles ->
//     HOLD_LAST_EN: slice0 keeps {0,dest,11}; undefined: slice0=0.

Source files
------------

// File: rtl/demux_class_n.sv
// demux_class_n: 1-to-NUM_CH class demux with per-channel push strobes.
// Ports: clk, reset_L (sync, active low), in_valid/data_in/class_in/dest_in,
//   out_full[NUM_CH] in; in_ready, out_data[NUM_CH*OUT_W], out_valid[NUM_CH],
//   err_drop, drop_cnt[CNT_W] out. Slice k = {class, dest, data}.
//   Build option: define HOLD_LAST_EN to keep slice k after its push;
//   without it, slice k reads 0 whenever out_valid[k]=0.
module demux_class_n #(
  parameter int DATA_W = 8,
  parameter int CLS_W  = 2,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int OUT_W = DATA_W + 1 + CLS_W
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [CLS_W-1:0]        class_in,
  input  logic                    dest_in,
  input  logic [NUM_CH-1:0]       out_full,
  output logic                    in_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        drop_cnt
);

  logic [NUM_CH*OUT_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]       valid_q, valid_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic             cls_bad;
  logic             full_sel;
  logic             accept;
  logic [OUT_W-1:0] word;

  // Extra top bit so NUM_CH == 2**CLS_W does not truncate to zero.
  assign cls_bad = {1'b0, class_in} >= (CLS_W+1)'(NUM_CH);

  // Full flag of the addressed channel; out-of-range classes read 0.
  always_comb begin
    full_sel = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (class_in == CLS_W'(k)) full_sel = out_full[k];
    end
  end

  assign in_ready = reset_L & (cls_bad | ~full_sel);
  assign accept   = in_valid & in_ready;
  assign word     = {class_in, dest_in, data_in};

  always_comb begin
    valid_d = '0;
`ifdef HOLD_LAST_EN
    data_d  = data_q;
`else
    data_d  = '0;
`endif
    err_d   = accept & cls_bad;
    cnt_d   = cnt_q;
    if (err_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (accept && !cls_bad && class_in == CLS_W'(k)) begin
        valid_d[k]                = 1'b1;
        data_d[k*OUT_W +: OUT_W] = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err_drop  = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_class_n.sv
// tb_demux_class_n: bench for demux_class_n, NUM_CH=4 and NUM_CH=3.
// Both instances share stimulus; a behavioural model predicts outputs.
module tb_demux_class_n;

  localparam int OW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L;
  logic       in_valid;
  logic [7:0] data_in;
  logic [1:0] class_in;
  logic       dest_in;
  logic [3:0] out_full;

  logic        rdy4, err4;
  logic [43:0] od4;
  logic [3:0]  ov4;
  logic [7:0]  cnt4;
  logic        rdy3, err3;
  logic [32:0] od3;
  logic [2:0]  ov3;
  logic [7:0]  cnt3;

  demux_class_n #(.NUM_CH(4)) dut4 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid),
    .data_in(data_in), .class_in(class_in), .dest_in(dest_in),
    .out_full(out_full), .in_ready(rdy4), .out_data(od4),
    .out_valid(ov4), .err_drop(err4), .drop_cnt(cnt4));

  demux_class_n #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid),
    .data_in(data_in), .class_in(class_in), .dest_in(dest_in),
    .out_full(out_full[2:0]), .in_ready(rdy3), .out_data(od3),
    .out_valid(ov3), .err_drop(err3), .drop_cnt(cnt3));

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: [instance][channel]; instance 0 = 4 ch, 1 = 3 ch.
  int          nch[2] = '{4, 3};
  logic [10:0] m_slice[2][4];
  logic        m_valid[2][4];
  logic        m_err[2];
  int          m_cnt[2];
  logic        e_rdy[2];

  task automatic tick();
    bit bad;
    bit acc;
    #1;
    for (int i = 0; i < 2; i++) begin
      bad      = int'(class_in) >= nch[i];
      e_rdy[i] = reset_L && (bad || !out_full[class_in]);
      acc      = in_valid && e_rdy[i];
      if (!reset_L) begin
        for (int k = 0; k < 4; k++) begin
          m_valid[i][k] = 1'b0;
          m_slice[i][k] = '0;
        end
        m_err[i] = 1'b0;
        m_cnt[i] = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          m_valid[i][k] = 1'b0;
`ifndef HOLD_LAST_EN
          m_slice[i][k] = '0;
`endif
        end
        m_err[i] = acc && bad;
        if (m_err[i] && m_cnt[i] < 255) m_cnt[i]++;
        if (acc && !bad) begin
          m_valid[i][class_in] = 1'b1;
          m_slice[i][class_in] = {class_in, dest_in, data_in};
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] x_od4();
    logic [43:0] r;
    for (int k = 0; k < 4; k++) r[k*OW +: OW] = m_slice[0][k];
    return r;
  endfunction

  function automatic logic [3:0] x_ov4();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_valid[0][k];
    return r;
  endfunction

  function automatic logic [32:0] x_od3();
    logic [32:0] r;
    for (int k = 0; k < 3; k++) r[k*OW +: OW] = m_slice[1][k];
    return r;
  endfunction

  function automatic logic [2:0] x_ov3();
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = m_valid[1][k];
    return r;
  endfunction

  task automatic test_reset();
    reset_L  = 1'b0;
    in_valid = 1'b1;
    class_in = 2'd1;
    data_in  = 8'($urandom);
    dest_in  = 1'b1;
    out_full = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (rdy4 !== 1'b0) $display("FAIL rst_rdy got %b exp 0", rdy4);
      else n_pass++;
      n_chk++;
      if ({od4, ov4, err4, cnt4} !== '0)
        $display("FAIL rst_out got %h/%h/%b/%0d exp 0", od4, ov4, err4, cnt4);
      else n_pass++;
      n_chk++;
      if ({od3, ov3, err3, cnt3} !== '0)
        $display("FAIL rst_out3 got %h/%h/%b/%0d exp 0", od3, ov3, err3, cnt3);
      else n_pass++;
    end
    reset_L  = 1'b1;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_routing();
    in_valid = 1'b1;
    data_in  = 8'hA5;
    class_in = 2'd2;
    dest_in  = 1'b1;
    tick();
    n_chk++;
    if (ov4 !== 4'b0100) $display("FAIL route_v1 got %b exp 0100", ov4);
    else n_pass++;
    n_chk++;
    if (od4[2*OW +: OW] !== {2'd2, 1'b1, 8'hA5})
      $display("FAIL route_s2 got %h exp %h", od4[2*OW +: OW], {2'd2, 1'b1, 8'hA5});
    else n_pass++;
    data_in  = 8'h3C;
    class_in = 2'd0;
    dest_in  = 1'b0;
    tick();
    n_chk++;
    if (ov4 !== 4'b0001) $display("FAIL route_v2 got %b exp 0001", ov4);
    else n_pass++;
    n_chk++;
    if (od4[0 +: OW] !== {2'd0, 1'b0, 8'h3C})
      $display("FAIL route_s0 got %h exp %h", od4[0 +: OW], {2'd0, 1'b0, 8'h3C});
    else n_pass++;
    n_chk++;
    if (od4 !== x_od4()) $display("FAIL route_all got %h exp %h", od4, x_od4());
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (ov4 !== 4'b0000) $display("FAIL route_idle got %b exp 0000", ov4);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_full = 4'b0010;
    in_valid = 1'b1;
    class_in = 2'd3;
    data_in  = 8'h9D;
    dest_in  = 1'b0;
    tick();
    n_chk++;
    if (rdy4 !== 1'b1 || ov4 !== 4'b1000)
      $display("FAIL bp_cls3 got rdy=%b v=%b exp rdy=1 v=1000", rdy4, ov4);
    else n_pass++;
    class_in = 2'd1;
    data_in  = 8'h5E;
    dest_in  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if (rdy4 !== 1'b0 || ov4 !== 4'b0000)
        $display("FAIL bp_stall got rdy=%b v=%b exp rdy=0 v=0000", rdy4, ov4);
      else n_pass++;
    end
    out_full = 4'b0000;
    tick();
    n_chk++;
    if (ov4 !== 4'b0010 || od4[OW +: OW] !== {2'd1, 1'b1, 8'h5E})
      $display("FAIL bp_push got v=%b s=%h exp v=0010 s=%h",
               ov4, od4[OW +: OW], {2'd1, 1'b1, 8'h5E});
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (ov4 !== 4'b0000) $display("FAIL bp_dup got %b exp 0000", ov4);
    else n_pass++;
  endtask

  task automatic test_drop();
    in_valid = 1'b1;
    class_in = 2'd3;
    out_full = 4'b0000;
    for (int c = 0; c < 300; c++) begin
      data_in = 8'($urandom);
      dest_in = 1'($urandom);
      tick();
      n_chk++;
      if (err3 !== 1'b1 || ov3 !== 3'b000 || cnt3 !== 8'(m_cnt[1]))
        $display("FAIL drop got e=%b v=%b n=%0d exp e=1 v=000 n=%0d",
                 err3, ov3, cnt3, m_cnt[1]);
      else n_pass++;
      n_chk++;
      if (ov4 !== 4'b1000 || od4 !== x_od4() || err4 !== 1'b0)
        $display("FAIL drop_b2b got v=%b d=%h e=%b exp v=1000 d=%h e=0",
                 ov4, od4, err4, x_od4());
      else n_pass++;
    end
    n_chk++;
    if (cnt3 !== 8'd255) $display("FAIL drop_sat got %0d exp 255", cnt3);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (err3 !== 1'b0 || cnt3 !== 8'd255)
      $display("FAIL drop_idle got e=%b n=%0d exp e=0 n=255", err3, cnt3);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    class_in = 2'd1;
    data_in  = 8'h77;
    dest_in  = 1'($urandom);
    tick();
    n_chk++;
    if (ov4 !== 4'b0010) $display("FAIL rmid_push got %b exp 0010", ov4);
    else n_pass++;
    reset_L  = 1'b0;
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (ov4 !== 4'b0000 || od4[OW +: OW] !== '0)
      $display("FAIL rmid_clr got v=%b s=%h exp v=0000 s=0", ov4, od4[OW +: OW]);
    else n_pass++;
    n_chk++;
    if (cnt3 !== 8'd0) $display("FAIL rmid_cnt got %0d exp 0", cnt3);
    else n_pass++;
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_hold();
    logic [10:0] want;
    in_valid = 1'b1;
    class_in = 2'd0;
    data_in  = 8'h11;
    dest_in  = 1'b1;
    tick();
    n_chk++;
    if (ov4 !== 4'b0001) $display("FAIL hold_push got %b exp 0001", ov4);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    tick();
`ifdef HOLD_LAST_EN
    want = {2'd0, 1'b1, 8'h11};
`else
    want = '0;
`endif
    n_chk++;
    if (od4[0 +: OW] !== want || ov4 !== 4'b0000)
      $display("FAIL hold_idle got s=%h v=%b exp s=%h v=0000",
               od4[0 +: OW], ov4, want);
    else n_pass++;
  endtask

  task automatic test_random();
    bit stalled;
    for (int c = 0; c < 600; c++) begin
      stalled = in_valid && reset_L && !(e_rdy[0] && e_rdy[1]);
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        class_in = 2'($urandom);
        data_in  = 8'($urandom);
        dest_in  = 1'($urandom);
      end
      out_full = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      reset_L  = ($urandom_range(0, 49) != 0);
      tick();
      n_chk++;
      if (rdy4 !== e_rdy[0] || rdy3 !== e_rdy[1])
        $display("FAIL rnd_rdy got %b%b exp %b%b", rdy4, rdy3, e_rdy[0], e_rdy[1]);
      else n_pass++;
      n_chk++;
      if (ov4 !== x_ov4() || od4 !== x_od4() ||
          err4 !== m_err[0] || cnt4 !== 8'(m_cnt[0]))
        $display("FAIL rnd4 got %b %h %b %0d exp %b %h %b %0d", ov4, od4, err4,
                 cnt4, x_ov4(), x_od4(), m_err[0], m_cnt[0]);
      else n_pass++;
      n_chk++;
      if (ov3 !== x_ov3() || od3 !== x_od3() ||
          err3 !== m_err[1] || cnt3 !== 8'(m_cnt[1]))
        $display("FAIL rnd3 got %b %h %b %0d exp %b %h %b %0d", ov3, od3, err3,
                 cnt3, x_ov3(), x_od3(), m_err[1], m_cnt[1]);
      else n_pass++;
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    class_in = '0;
    dest_in  = 1'b0;
    out_full = '0;
    for (int i = 0; i < 2; i++) begin
      e_rdy[i] = 1'b0;
      m_err[i] = 1'b0;
      m_cnt[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_slice[i][k] = '0;
        m_valid[i][k] = 1'b0;
      end
    end
    @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
